// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared AHB-Lite encodings for the slave memory.
//   HTRANS codes, HRESP codes and the slave data-phase FSM state encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // IDLE : no data phase in progress
    // WAIT : OKAY data phase being stretched by the wait counter
    // LAST : final (ready) cycle of an OKAY data phase
    // ERR1 : first ERROR cycle (not ready)
    // ERR2 : second ERROR cycle (ready)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem -- AHB-Lite slave backed by a small word-addressed register file.
//   Parameters: WAIT_STATES (0..7 data-phase waits on OKAY transfers),
//               BASE_ADDR (window base), MEM_WORDS (32-bit words, power of two, >= 2).
//   Ports:
//     Hclk, Hresetn         clock, async active-low reset
//     Haddr, Htrans, Hwrite address-phase controls (sampled when Hreadyin=1)
//     Hwdata                write data, valid in the data phase
//     Hreadyin              bus HREADY
//     Hreadyout, Hresp      data-phase handshake / response
//     Hrdata                read data, non-zero only in a read LAST cycle
//   Out-of-window addresses get the two-cycle ERROR response and never touch storage.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned MEM_WORDS   = 32
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [31:0] Haddr,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [31:0] Hwdata,
    input  logic        Hreadyin,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    // One bit wider than the bus so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [2:0]                   r_cnt;
    logic [2:0]                   w_cnt_nxt;
    logic                         r_write;
    logic [IDX_W-1:0]             r_idx;
    logic [MEM_WORDS-1:0][31:0]   r_mem;
    logic                         w_open;
    logic                         w_accept;
    logic                         w_in_range;

    // An address phase can only complete while our own data phase is ready.
    assign w_open     = (r_state == ST_IDLE) || (r_state == ST_LAST) || (r_state == ST_ERR2);
    assign w_accept   = w_open && Hreadyin &&
                        ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
    assign w_in_range = (Haddr >= BASE_ADDR) && ({1'b0, Haddr} < END_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) w_state_nxt = ST_LAST;
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                // IDLE, LAST and ERR2 all behave as the pipelined accept point.
                if (!w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_in_range) begin
                    w_state_nxt = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = 3'(WAIT_STATES);
                end else begin
                    w_state_nxt = ST_LAST;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= Hwrite;
                r_idx   <= Haddr[IDX_W+1:2];
            end
        end
    end

    // Write lands at the end of LAST, so a read accepted in that same cycle
    // sees the new value in its own data phase.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_mem <= '0;
        end else if ((r_state == ST_LAST) && r_write) begin
            r_mem[r_idx] <= Hwdata;
        end
    end

    assign Hreadyout = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    assign Hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign Hrdata    = ((r_state == ST_LAST) && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem -- two slaves (1 wait state and 0 wait states) driven by a
// pipelined AHB master task; expectations come from a word-array model and are
// queued at issue, then consumed by a negedge monitor as data phases complete.
module tb_ahb_slave_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          WORDS = 32;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        int          waits;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic [1:0]  hresetn;
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    wire  [1:0]  hreadyout;
    wire  [1:0]  hresp  [2];
    wire  [31:0] hrdata [2];

    int errors = 0;
    int checks = 0;

    xfer_t       stim[$];
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [2][WORDS];
    bit          active [2];
    int          waits  [2];
    bit          wbad   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahb_slave_mem #(.WAIT_STATES(1), .BASE_ADDR(BASE), .MEM_WORDS(WORDS)) u_ws1 (
        .Hclk(clk), .Hresetn(hresetn[0]), .Haddr(haddr[0]), .Htrans(htrans[0]),
        .Hwrite(hwrite[0]), .Hwdata(hwdata[0]), .Hreadyin(hreadyout[0]),
        .Hreadyout(hreadyout[0]), .Hresp(hresp[0]), .Hrdata(hrdata[0])
    );

    ahb_slave_mem #(.WAIT_STATES(0), .BASE_ADDR(BASE), .MEM_WORDS(WORDS)) u_ws0 (
        .Hclk(clk), .Hresetn(hresetn[1]), .Haddr(haddr[1]), .Htrans(htrans[1]),
        .Hwrite(hwrite[1]), .Hwdata(hwdata[1]), .Hreadyin(hreadyout[1]),
        .Hreadyout(hreadyout[1]), .Hresp(hresp[1]), .Hrdata(hrdata[1])
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic check(input bit ok, input string name, input int d,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, got, want, $time);
        end
    endtask

    task automatic add(input logic [1:0] t, input logic w, input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.trans = t; x.write = w; x.addr = a; x.wdata = wd;
        stim.push_back(x);
    endtask

    // Reference behaviour: window decode by plain arithmetic on the address.
    task automatic model_push(input int d, input xfer_t x);
        exp_t e;
        bit   inr;
        int   idx;
        inr = (x.addr >= BASE) && (x.addr < BASE + 32'(4 * WORDS));
        idx = inr ? int'((x.addr - BASE) >> 2) : 0;
        e.waits = inr ? ws_of(d) : 1;
        e.resp  = inr ? 2'b00 : 2'b01;
        e.rdata = (inr && !x.write) ? ref_mem[d][idx] : 32'h0;
        if (inr && x.write) ref_mem[d][idx] = x.wdata;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic present(input int d, output xfer_t cur);
        xfer_t x;
        if (stim.size() > 0) x = stim.pop_front();
        else begin x.trans = T_IDLE; x.write = 1'b0; x.addr = 32'h0; x.wdata = 32'h0; end
        haddr[d]  = x.addr;
        htrans[d] = x.trans;
        hwrite[d] = x.write;
        if (x.trans[1]) model_push(d, x);
        cur = x;
    endtask

    // Pipelined master: call at posedge+1; the first address is driven at once.
    task automatic run(input int d);
        xfer_t cur;
        logic  rdy;
        int    guard;
        guard = 0;
        present(d, cur);
        forever begin
            @(negedge clk); rdy = hreadyout[d];
            @(posedge clk); #1;
            if (rdy) begin
                hwdata[d] = (cur.trans[1] && cur.write) ? cur.wdata : 32'h0;
                if (!cur.trans[1] && stim.size() == 0) break;
                present(d, cur);
            end
            guard++;
            if (guard > 2000) begin
                check(1'b0, "run_timeout", d, 32'(guard), 32'd2000);
                stim.delete();
                break;
            end
        end
    endtask

    task automatic mon_step(input int d);
        exp_t e;
        bit   acc;
        if (!hresetn[d]) begin
            active[d] = 0; waits[d] = 0; wbad[d] = 0;
            return;
        end
        if (active[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                check(1'b0, "unexpected_phase", d, 32'd1, 32'd0);
                active[d] = 0;
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                if (!hreadyout[d]) begin
                    waits[d]++;
                    if (hresp[d] != e.resp || hrdata[d] != 32'h0) wbad[d] = 1;
                end else begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    check(waits[d] == e.waits, "wait_cycles", d, 32'(waits[d]), 32'(e.waits));
                    check(hresp[d] == e.resp, "resp", d, 32'(hresp[d]), 32'(e.resp));
                    check(hrdata[d] == e.rdata, "rdata", d, hrdata[d], e.rdata);
                    check(!wbad[d], "wait_outputs", d, 32'(wbad[d]), 32'd0);
                    waits[d] = 0; wbad[d] = 0;
                end
            end
        end else begin
            check(hreadyout[d] && hresp[d] == 2'b00 && hrdata[d] == 32'h0, "idle_outputs", d,
                  {hreadyout[d], 1'b0, hresp[d], hrdata[d][27:0]}, 32'h8000_0000);
        end
        acc = hreadyout[d] && htrans[d][1];
        active[d] = (active[d] && !hreadyout[d]) || acc;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t cur;
        hresetn = 2'b00;
        for (int d = 0; d < 2; d++) begin
            haddr[d] = 32'h0; htrans[d] = T_IDLE; hwrite[d] = 1'b0; hwdata[d] = 32'h0;
            for (int i = 0; i < WORDS; i++) ref_mem[d][i] = 32'h0;
            active[d] = 0; waits[d] = 0; wbad[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check(hreadyout[d] == 1'b1, "reset_ready", d, 32'(hreadyout[d]), 32'd1);
            check(hresp[d] == 2'b00, "reset_resp", d, 32'(hresp[d]), 32'd0);
            check(hrdata[d] == 32'h0, "reset_rdata", d, hrdata[d], 32'h0);
        end
        // Release at posedge+1 and present at once: first edge after release accepts.
        hresetn = 2'b11;

        // single write / read with one wait state
        add(T_NS, 1, 32'h8000_0004, 32'h0000_00A3);
        add(T_NS, 0, 32'h8000_0004, 32'h0);
        run(0);

        // INCR4 write then back-to-back reads, zero wait states
        add(T_NS,  1, 32'h8000_0010, 32'h1111_0010);
        add(T_SEQ, 1, 32'h8000_0014, 32'h1111_0014);
        add(T_SEQ, 1, 32'h8000_0018, 32'h1111_0018);
        add(T_SEQ, 1, 32'h8000_001C, 32'h1111_001C);
        add(T_NS,  0, 32'h8000_0010, 32'h0);
        add(T_SEQ, 0, 32'h8000_0014, 32'h0);
        add(T_SEQ, 0, 32'h8000_0018, 32'h0);
        add(T_SEQ, 0, 32'h8000_001C, 32'h0);
        run(1);

        // WRAP4 from 0x48, readback in wrapped order
        add(T_NS,  1, 32'h8000_0048, 32'hC0DE_0048);
        add(T_SEQ, 1, 32'h8000_004C, 32'hC0DE_004C);
        add(T_SEQ, 1, 32'h8000_0040, 32'hC0DE_0040);
        add(T_SEQ, 1, 32'h8000_0044, 32'hC0DE_0044);
        add(T_NS,  0, 32'h8000_0048, 32'h0);
        add(T_SEQ, 0, 32'h8000_004C, 32'h0);
        add(T_SEQ, 0, 32'h8000_0040, 32'h0);
        add(T_SEQ, 0, 32'h8000_0044, 32'h0);
        run(0);

        // out-of-window accesses and window edges; read issued during ERR2
        add(T_NS, 1, 32'h8000_0000, 32'h1111_2222);
        add(T_NS, 1, 32'h8000_0100, 32'hDEAD_BEEF);
        add(T_NS, 0, 32'h8000_0004, 32'h0);
        add(T_NS, 0, 32'h8000_0000, 32'h0);
        add(T_NS, 0, 32'h8000_0100, 32'h0);
        add(T_NS, 1, 32'h7FFF_FFFC, 32'hBAD0_0001);
        add(T_NS, 1, 32'h8000_0080, 32'hBAD0_0002);
        add(T_NS, 1, 32'h8000_007C, 32'h7C7C_7C7C);
        add(T_NS, 0, 32'h8000_007C, 32'h0);
        add(T_NS, 0, 32'h8000_0000, 32'h0);
        run(0);

        // IDLE/BUSY carry no transfer; low address bits are ignored
        add(T_IDLE, 1, 32'h8000_0010, 32'hFFFF_0000);
        add(T_BUSY, 1, 32'h8000_0014, 32'hFFFF_0001);
        add(T_NS,   0, 32'h8000_0010, 32'h0);
        add(T_NS,   0, 32'h8000_0014, 32'h0);
        add(T_NS,   1, 32'h8000_0023, 32'hABCD_0023);
        add(T_NS,   0, 32'h8000_0020, 32'h0);
        run(1);

        // randomized traffic on both slaves
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0)
                    a = $urandom_range(0, 1) ? BASE + 32'h80 + $urandom_range(0, 255)
                                             : BASE - 32'd1 - $urandom_range(0, 255);
                else
                    a = BASE + $urandom_range(0, 127);
                add(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
            end
            run(d);
        end

        // reset during the wait cycle of a write to 0x08
        add(T_NS, 1, 32'h8000_0008, 32'h0BAD_F00D);
        run(0);
        add(T_NS, 1, 32'h8000_0008, 32'h5555_AAAA);
        present(0, cur);
        @(posedge clk); #1;
        hwdata[0] = cur.wdata;
        htrans[0] = T_IDLE;
        @(negedge clk); #1;
        hresetn[0] = 1'b0;
        #1;
        check(hreadyout[0] == 1'b1, "midreset_ready", 0, 32'(hreadyout[0]), 32'd1);
        check(hresp[0] == 2'b00, "midreset_resp", 0, 32'(hresp[0]), 32'd0);
        check(hrdata[0] == 32'h0, "midreset_rdata", 0, hrdata[0], 32'h0);
        q0.delete();
        for (int i = 0; i < WORDS; i++) ref_mem[0][i] = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        hresetn[0] = 1'b1;
        hwdata[0]  = 32'h0;
        add(T_NS, 0, 32'h8000_0008, 32'h0);
        add(T_NS, 0, 32'h8000_0004, 32'h0);
        run(0);

        repeat (3) @(posedge clk);
        check(q0.size() == 0, "drain", 0, 32'(q0.size()), 32'd0);
        check(q1.size() == 0, "drain", 1, 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 The block SHALL use one clock and one reset: clock Hclk (rising edge), reset Hresetn, asynchronous, active-low.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- WAIT_STATES, 1, data-phase wait cycles for OKAY transfers, legal range 0..7.
- BASE_ADDR, 32'h8000_0000, base of the decoded window.
- MEM_WORDS, 32, number of 32-bit storage words (power of two).
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- Hclk, in, 1, clock.
- Hresetn, in, 1, async active-low reset.
- Haddr, in, 32, address-phase address.
- Htrans, in, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- Hwrite, in, 1, 1=write, 0=read.
- Hwdata, in, 32, write data, valid in the data phase.
- Hreadyin, in, 1, bus HREADY; address phase is sampled only when this is 1.
- Hreadyout, out, 1, 0 extends the current data phase.
- Hresp, out, 2, OKAY=00, ERROR=01.
- Hrdata, out, 32, read data, valid when Hreadyout=1 in a read data phase.

Function
REQ-004 An address phase SHALL be accepted on a rising Hclk edge only when Hreadyin=1 and Htrans is NONSEQ or SEQ; IDLE and BUSY SHALL produce a zero-wait OKAY data phase with no storage access.
REQ-005 On accept, the block SHALL register Hwrite, word index Haddr[log2(MEM_WORDS)+1:2] and an in-range flag (BASE_ADDR <= Haddr < BASE_ADDR+4*MEM_WORDS); Haddr[1:0] SHALL be ignored and all accesses SHALL be full-word.
REQ-006 The FSM states SHALL be IDLE, WAIT, LAST, ERR1, ERR2.
REQ-007 From IDLE or LAST, an accepted in-range transfer SHALL go to WAIT if WAIT_STATES>0, else to LAST; an out-of-range transfer SHALL go to ERR1; no accept SHALL go to IDLE.
REQ-008 In WAIT, Hreadyout SHALL be 0 and Hresp SHALL be OKAY for exactly WAIT_STATES cycles (3-bit down-counter), then the FSM SHALL go to LAST.
REQ-009 In LAST, Hreadyout SHALL be 1 and Hresp SHALL be OKAY.
- Read: Hrdata SHALL equal mem[index].
- Write: mem[index] SHALL be loaded with Hwdata at the closing edge of that cycle.
REQ-010 In ERR1, Hreadyout SHALL be 0 and Hresp SHALL be ERROR; ERR1 SHALL go to ERR2.
REQ-011 In ERR2, Hreadyout SHALL be 1 and Hresp SHALL be ERROR; ERR2 SHALL then follow the same transitions as IDLE/LAST.
REQ-012 Errored transfers SHALL NOT modify storage, and Hrdata SHALL be 0 during them.
REQ-013 A new address phase SHALL be accepted in the same cycle as LAST or ERR2 (pipelined back-to-back); no address SHALL be accepted in WAIT or ERR1, because Hreadyin=0 in those states.
REQ-014 Write followed immediately by read of the same word: the read data phase SHALL return the newly written value.
REQ-015 Hrdata SHALL be 0 outside a read LAST cycle.
REQ-016 SEQ transfers SHALL be treated identically to NONSEQ, so INCR and WRAP bursts need no burst-length tracking; each beat SHALL incur WAIT_STATES waits.

Reset
REQ-017 While Hresetn=0, regardless of any transfer in progress:
- FSM SHALL be IDLE and the counter SHALL be 0.
- Hreadyout SHALL be 1, Hresp SHALL be 00 and Hrdata SHALL be 0.
- All storage words SHALL be 0.
- A transfer interrupted by reset SHALL be discarded with no write.
REQ-018 The first address phase SHALL be accepted on the first rising edge after Hresetn deasserts.

Structure
REQ-019 Shared package ahb_pkg SHALL hold the HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), the HRESP codes (OKAY/ERROR) and the FSM state encoding.
REQ-020 The block SHALL be a single module with no sub-module; storage, decode, counter and FSM SHALL be inline.

Verification
REQ-021 WAIT_STATES=1, write NONSEQ 32'h8000_0004 with Hwdata=32'h0000_00A3 -> Hreadyout 0 for 1 cycle then 1, Hresp=00; read of 32'h8000_0004 -> Hrdata=32'h0000_00A3.
REQ-022 WAIT_STATES=0, INCR4 write to 32'h8000_0010..1C followed by a back-to-back read of 32'h8000_0010 -> every beat has zero waits and the read returns the first beat's data.
REQ-023 WRAP4 write starting at 32'h8000_0048 (beats 48, 4C, 40, 44) -> readback of all four words matches in wrapped order.
REQ-024 Write to 32'h8000_0100 -> ERR1 (Hreadyout=0, Hresp=01) then ERR2 (Hreadyout=1, Hresp=01); storage unchanged; a NONSEQ read issued during ERR2 completes OKAY.
REQ-025 Htrans=IDLE or BUSY with Hreadyin=1 -> Hreadyout=1, Hresp=00, no storage change.
REQ-026 Hresetn asserted during a WAIT cycle of a write to 32'h8000_0008 -> outputs take reset values immediately (Hreadyout=1, Hresp=00, Hrdata=0); a later read of 32'h8000_0008 returns 0.
